// File: rtl/elevator_pkg.sv
// Shared floor encodings, dispatcher state type and call-code helpers for the
// three-floor elevator (car controller and call dispatcher).
package elevator_pkg;

   localparam logic [1:0] FLOOR1 = 2'b00;
   localparam logic [1:0] FLOOR2 = 2'b01;
   localparam logic [1:0] FLOOR3 = 2'b10;

   typedef enum logic [1:0] {
      DOOR_OPEN,
      CLOSED,
      MOVING
   } state_e;

   typedef struct packed {
      logic       flip;
      logic [1:0] floor;
   } pick_t;

   function automatic logic [2:0] floor_mask(input logic [1:0] floor);
      return 3'b001 << floor;
   endfunction

   // No-movement code; an invalid floor is treated as floor 1.
   function automatic logic [1:0] hold_code(input logic [1:0] cur);
      return (cur == FLOOR2) ? 2'b01 : 2'b11;
   endfunction

   // {B1,B0} that sends the car from cur to tgt.
   function automatic logic [1:0] call_code(input logic [1:0] cur, input logic [1:0] tgt);
      logic [1:0] code;
      case (tgt)
         FLOOR1:  code = 2'b00;
         FLOOR2:  code = 2'b10;
         FLOOR3:  code = (cur == FLOOR2) ? 2'b11 : 2'b01;
         default: code = hold_code(cur);
      endcase
      return code;
   endfunction

endpackage

// File: rtl/elevator_call_dispatcher_if.sv
// Button/panel and car-controller signals of the call dispatcher.
interface elevator_call_dispatcher_if;
   logic [2:0] call_req;
   logic [1:0] EA;
   logic       P;
   logic       B0;
   logic       B1;
   logic [2:0] pending;
   logic       busy;
   logic       fault;

   modport master (
      input  call_req, EA,
      output P, B0, B1, pending, busy, fault
   );

   modport slave (
      output call_req, EA,
      input  P, B0, B1, pending, busy, fault
   );
endinterface

// File: rtl/door_dwell_timer.sv
// Loadable down-counter: reloads to LoadVal (also its reset value), decrements
// while enabled and flags expiry when the count reaches 1.
module door_dwell_timer #(
   parameter int unsigned Width   = 8,
   parameter int unsigned LoadVal = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic expire_o
);
   logic [Width-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = Width'(LoadVal);
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= Width'(LoadVal);
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == Width'(1));
endmodule

// File: rtl/elevator_call_dispatcher.sv
// Latches floor calls, picks the next target and drives P/B1/B0 to the car FSM.
// Optional MOVING watchdog: define CALL_DISPATCH_WATCHDOG_EN.
module elevator_call_dispatcher
   import elevator_pkg::*;
#(
   parameter int unsigned DOOR_CYCLES  = 8,
   parameter int unsigned MOVE_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   elevator_call_dispatcher_if.master bus
);
   // One width for both counters so the timer module is shared unchanged.
   localparam int unsigned CntW =
      ($clog2(MOVE_TIMEOUT + 1) > 8) ? $clog2(MOVE_TIMEOUT + 1) : 8;

   state_e     state_d, state_q;
   logic       dir_up_d, dir_up_q;
   logic [1:0] target_d, target_q;
   logic [1:0] code_d, code_q;
   logic [2:0] pending_d, pending_q;
   logic       p_d, p_q;
   logic       busy_d, busy_q;

   logic [1:0] cur_floor;
   logic [2:0] cur_mask;
   logic [2:0] latch_mask;
   logic [2:0] clr_mask;
   logic       dwell_load;
   logic       dwell_expire;
   pick_t      sel;

   function automatic pick_t pick_target(input logic [1:0] cur, input logic [2:0] pend,
                                         input logic up);
      pick_t      r;
      logic [1:0] above, below;
      logic       has_above, has_below;
      above     = cur;
      below     = cur;
      has_above = 1'b0;
      has_below = 1'b0;
      for (int f = 2; f >= 0; f--) begin
         if ((f > int'(cur)) && pend[2'(f)]) begin
            above     = 2'(f);
            has_above = 1'b1;
         end
      end
      for (int f = 0; f < 3; f++) begin
         if ((f < int'(cur)) && pend[2'(f)]) begin
            below     = 2'(f);
            has_below = 1'b1;
         end
      end
      r.flip  = up ? !has_above : !has_below;
      r.floor = up ? (has_above ? above : below) : (has_below ? below : above);
      return r;
   endfunction

`ifdef CALL_DISPATCH_WATCHDOG_EN
   logic fault_d, fault_q;
   logic wd_load;
   logic wd_expire;

   door_dwell_timer #(
      .Width   (CntW),
      .LoadVal (MOVE_TIMEOUT)
   ) u_move_watchdog (
      .clk      (clk),
      .reset    (reset),
      .load_i   (wd_load),
      .dec_i    (state_q == MOVING),
      .expire_o (wd_expire)
   );
`endif

   door_dwell_timer #(
      .Width   (CntW),
      .LoadVal (DOOR_CYCLES)
   ) u_door_dwell (
      .clk      (clk),
      .reset    (reset),
      .load_i   (dwell_load),
      .dec_i    (state_q == DOOR_OPEN),
      .expire_o (dwell_expire)
   );

   always_comb begin
      cur_floor  = (bus.EA == 2'b11) ? FLOOR1 : bus.EA;
      cur_mask   = floor_mask(cur_floor);
      sel        = pick_target(cur_floor, pending_q, dir_up_q);
      state_d    = state_q;
      dir_up_d   = dir_up_q;
      target_d   = target_q;
      code_d     = hold_code(cur_floor);
      latch_mask = bus.call_req;
      clr_mask   = 3'b000;
      dwell_load = 1'b0;
`ifdef CALL_DISPATCH_WATCHDOG_EN
      fault_d    = fault_q;
      wd_load    = 1'b0;
`endif

      unique case (state_q)
         DOOR_OPEN: begin
            // A call for the floor the car is open at just keeps the door open.
            if ((bus.call_req & cur_mask) != 3'b000) begin
               latch_mask = bus.call_req & ~cur_mask;
               dwell_load = 1'b1;
            end else if (dwell_expire) begin
               state_d = CLOSED;
            end
         end
         CLOSED: begin
            if ((pending_q & cur_mask) != 3'b000) begin
               clr_mask   = cur_mask;
               state_d    = DOOR_OPEN;
               dwell_load = 1'b1;
            end else if (pending_q != 3'b000) begin
               target_d = sel.floor;
               dir_up_d = sel.flip ? !dir_up_q : dir_up_q;
               code_d   = call_code(cur_floor, sel.floor);
               state_d  = MOVING;
`ifdef CALL_DISPATCH_WATCHDOG_EN
               wd_load  = 1'b1;
`endif
            end
         end
         MOVING: begin
            code_d = code_q;
            if ((bus.EA != 2'b11) && (bus.EA == target_q)) begin
               clr_mask   = floor_mask(target_q);
               code_d     = hold_code(cur_floor);
               state_d    = DOOR_OPEN;
               dwell_load = 1'b1;
`ifdef CALL_DISPATCH_WATCHDOG_EN
            end else if (wd_expire) begin
               fault_d    = 1'b1;
               clr_mask   = floor_mask(target_q);
               code_d     = hold_code(cur_floor);
               state_d    = DOOR_OPEN;
               dwell_load = 1'b1;
`endif
            end
         end
         default: begin
            state_d    = DOOR_OPEN;
            dwell_load = 1'b1;
         end
      endcase

      // Clear-on-serve beats a simultaneous request for the same floor.
      pending_d = (pending_q | latch_mask) & ~clr_mask;
      p_d       = (state_d != DOOR_OPEN);
      busy_d    = (state_d == MOVING);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= DOOR_OPEN;
         dir_up_q  <= 1'b1;
         target_q  <= FLOOR1;
         code_q    <= 2'b11;
         pending_q <= 3'b000;
         p_q       <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_up_q  <= dir_up_d;
         target_q  <= target_d;
         code_q    <= code_d;
         pending_q <= pending_d;
         p_q       <= p_d;
         busy_q    <= busy_d;
      end
   end

`ifdef CALL_DISPATCH_WATCHDOG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
   assign bus.fault = fault_q;
`else
   assign bus.fault = 1'b0;
`endif

   assign bus.P       = p_q;
   assign bus.B1      = code_q[1];
   assign bus.B0      = code_q[0];
   assign bus.pending = pending_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher; the car controller is played by
// hand-driven EA steps. Covers both builds of CALL_DISPATCH_WATCHDOG_EN.
module tb_elevator_call_dispatcher;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   elevator_call_dispatcher_if bus ();

   elevator_call_dispatcher #(
      .DOOR_CYCLES  (8),
      .MOVE_TIMEOUT (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic p, input logic [1:0] code,
                          input logic [2:0] pend, input logic busy);
      chk({tag, ".P"}, 8'(bus.P), 8'(p));
      chk({tag, ".code"}, 8'({bus.B1, bus.B0}), 8'(code));
      chk({tag, ".pending"}, 8'(bus.pending), 8'(pend));
      chk({tag, ".busy"}, 8'(bus.busy), 8'(busy));
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.call_req = 3'b000;
      bus.EA       = 2'b00;

      // Reset values, then the 8-cycle dwell at floor 1.
      tick(2);
      chk_out("reset", 1'b0, 2'b11, 3'b000, 1'b0);
      chk("reset.fault", 8'(bus.fault), 8'd0);
      reset = 1'b0;
      tick(7);
      chk_out("dwell7", 1'b0, 2'b11, 3'b000, 1'b0);
      tick(1);
      chk_out("closed", 1'b1, 2'b11, 3'b000, 1'b0);
      tick(1);
      chk_out("idle", 1'b1, 2'b11, 3'b000, 1'b0);

      // Current-floor call while closed reopens; repeated calls extend the dwell.
      bus.call_req = 3'b001;
      tick(1);
      chk_out("cur_latch", 1'b1, 2'b11, 3'b001, 1'b0);
      bus.call_req = 3'b000;
      tick(1);
      chk_out("cur_serve", 1'b0, 2'b11, 3'b000, 1'b0);
      bus.call_req = 3'b001;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk_out("extend", 1'b0, 2'b11, 3'b000, 1'b0);
      end
      bus.call_req = 3'b000;
      tick(7);
      chk_out("extend_end", 1'b0, 2'b11, 3'b000, 1'b0);
      tick(1);
      chk_out("reclosed", 1'b1, 2'b11, 3'b000, 1'b0);

      // Floor 3 call from floor 1.
      bus.call_req = 3'b100;
      tick(1);
      chk_out("up_latch", 1'b1, 2'b11, 3'b100, 1'b0);
      bus.call_req = 3'b000;
      tick(1);
      chk_out("up_move", 1'b1, 2'b01, 3'b100, 1'b1);
      bus.EA = 2'b10;
      tick(1);
      chk_out("up_arrive", 1'b0, 2'b11, 3'b000, 1'b0);

      // Floor 2 call from floor 3, a call latched mid-move, then reset in MOVING.
      bus.call_req = 3'b010;
      tick(1);
      chk_out("f2_latch", 1'b0, 2'b11, 3'b010, 1'b0);
      bus.call_req = 3'b000;
      tick(6);
      chk_out("f3_open", 1'b0, 2'b11, 3'b010, 1'b0);
      tick(1);
      chk_out("f3_closed", 1'b1, 2'b11, 3'b010, 1'b0);
      tick(1);
      chk_out("down_move", 1'b1, 2'b10, 3'b010, 1'b1);
      bus.call_req = 3'b001;
      tick(1);
      chk_out("move_latch", 1'b1, 2'b10, 3'b011, 1'b1);
      bus.call_req = 3'b000;
      reset = 1'b1;
      #1;
      chk_out("reset_move", 1'b0, 2'b11, 3'b000, 1'b0);
      chk("reset_move.fault", 8'(bus.fault), 8'd0);

      // Restart at floor 2, direction up, pending 101: floor 3 first, then floor 1.
      bus.EA = 2'b01;
      tick(1);
      reset = 1'b0;
      bus.call_req = 3'b101;
      tick(1);
      chk_out("f2_pend", 1'b0, 2'b01, 3'b101, 1'b0);
      bus.call_req = 3'b000;
      tick(6);
      chk_out("f2_open", 1'b0, 2'b01, 3'b101, 1'b0);
      tick(1);
      chk_out("f2_closed", 1'b1, 2'b01, 3'b101, 1'b0);
      tick(1);
      chk_out("to_f3", 1'b1, 2'b11, 3'b101, 1'b1);
      bus.EA = 2'b10;
      tick(1);
      chk_out("at_f3", 1'b0, 2'b11, 3'b001, 1'b0);
      tick(7);
      chk_out("f3_dwell", 1'b0, 2'b11, 3'b001, 1'b0);
      tick(1);
      chk_out("f3_close", 1'b1, 2'b11, 3'b001, 1'b0);
      tick(1);
      chk_out("to_f1", 1'b1, 2'b00, 3'b001, 1'b1);
      bus.EA = 2'b11;
      tick(1);
      chk_out("ea_invalid", 1'b1, 2'b00, 3'b001, 1'b1);
      bus.EA = 2'b00;
      tick(1);
      chk_out("at_f1", 1'b0, 2'b11, 3'b000, 1'b0);

      // Floor 2 request with EA stuck at floor 1.
      bus.call_req = 3'b010;
      tick(1);
      bus.call_req = 3'b000;
      tick(7);
      chk_out("wd_closed", 1'b1, 2'b11, 3'b010, 1'b0);
      tick(1);
      chk_out("wd_move", 1'b1, 2'b10, 3'b010, 1'b1);
      tick(15);
      chk_out("wd_pre", 1'b1, 2'b10, 3'b010, 1'b1);
      chk("wd_pre.fault", 8'(bus.fault), 8'd0);
      tick(1);
`ifdef CALL_DISPATCH_WATCHDOG_EN
      chk_out("wd_trip", 1'b0, 2'b11, 3'b000, 1'b0);
      chk("wd_trip.fault", 8'(bus.fault), 8'd1);
      tick(3);
      chk("wd_sticky.fault", 8'(bus.fault), 8'd1);
`else
      chk_out("wd_none", 1'b1, 2'b10, 3'b010, 1'b1);
      chk("wd_none.fault", 8'(bus.fault), 8'd0);
      bus.EA = 2'b01;
      tick(1);
      chk_out("wd_none_arrive", 1'b0, 2'b01, 3'b000, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
